// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Optional perf counters in inst_fetcher are enabled by defining IF_PERF_EN.
package inst_fetcher_pkg;

  localparam int          IF_QUEUE_DEPTH_BIT = 3;
  localparam logic [31:0] IF_RESET_PC        = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } if_entry_t;

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular instruction queue: registered slots, head read from the slot at rd_ptr.
// Flush empties the queue and takes priority over push and pop.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH_BIT = IF_QUEUE_DEPTH_BIT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush,
  input  logic                 push,
  input  if_entry_t            push_entry,
  input  logic                 pop,
  output if_entry_t            head,
  output logic [DEPTH_BIT:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  if_entry_t            slots [DEPTH];
  logic [DEPTH_BIT-1:0] rd_ptr;
  logic [DEPTH_BIT-1:0] wr_ptr;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding word read at a time, queued with its PC for the decoder.
// Define IF_PERF_EN to add the perf_fetched / perf_flushes counters.
//
// state   | meaning
// IF_IDLE | may issue a request at pc when the queue has room
// IF_WAIT | request accepted, response will be queued
// IF_DROP | request accepted before a redirect, response will be discarded
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH_BIT = IF_QUEUE_DEPTH_BIT,
  parameter logic [31:0] RESET_PC        = IF_RESET_PC
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        dec_valid,
  output logic [31:0] dec_inst_addr,
  output logic [31:0] dec_inst,
  input  logic        dec_accept,
  input  logic        dec_clear,
  input  logic [31:0] dec_set_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_set_addr
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  if_state_t                state;
  logic [31:0]              pc;
  logic [31:0]              req_pc;
  logic [31:0]              target;
  logic                     redirect;
  logic                     handshake;
  logic                     resp;
  logic                     push;
  logic                     pop;
  logic [QUEUE_DEPTH_BIT:0] count;
  if_entry_t                head;

  assign redirect = rdy_in && (rob_clear || dec_clear);
  assign target   = rob_clear ? rob_set_addr : dec_set_addr;
  assign resp     = rdy_in && mem_resp_valid;

  // count can only reach 2^N, so its MSB alone flags a full queue
  assign mem_req_valid = rst_in && rdy_in && (state == IF_IDLE) && !count[QUEUE_DEPTH_BIT];
  assign mem_req_addr  = pc;
  assign handshake     = mem_req_valid && mem_req_ready;

  assign dec_valid     = (count != '0);
  assign dec_inst_addr = head.addr;
  assign dec_inst      = head.inst;

  assign push = resp && (state == IF_WAIT) && !redirect;
  assign pop  = rdy_in && dec_valid && dec_accept && !redirect;

  inst_queue #(.DEPTH_BIT(QUEUE_DEPTH_BIT)) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .flush      (redirect),
    .push       (push),
    .push_entry ('{addr: req_pc, inst: mem_resp_data}),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state  <= IF_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (rdy_in) begin
      case (state)
        IF_IDLE: begin
          if (handshake) begin
            req_pc <= pc;
            state  <= redirect ? IF_DROP : IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (redirect) begin
            state <= resp ? IF_IDLE : IF_DROP;
          end else if (resp) begin
            pc    <= pc + 32'd4;
            state <= IF_IDLE;
          end
        end
        IF_DROP: begin
          if (resp) state <= IF_IDLE;
        end
        default: state <= IF_IDLE;
      endcase
      if (redirect) pc <= target;
    end
  end

`ifdef IF_PERF_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push)     perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed vector table, hand sequences, then random traffic
// checked against a queue-based reference model.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        dec_valid;
  logic [31:0] dec_inst_addr;
  logic [31:0] dec_inst;
  logic        dec_accept;
  logic        dec_clear;
  logic [31:0] dec_set_addr;
  logic        rob_clear;
  logic [31:0] rob_set_addr;

  inst_fetcher dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .dec_valid     (dec_valid),
    .dec_inst_addr (dec_inst_addr),
    .dec_inst      (dec_inst),
    .dec_accept    (dec_accept),
    .dec_clear     (dec_clear),
    .dec_set_addr  (dec_set_addr),
    .rob_clear     (rob_clear),
    .rob_set_addr  (rob_set_addr)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        rdy;
    logic        ready;
    logic        resp;
    logic [31:0] data;
    logic        acc;
    logic        dclr;
    logic [31:0] daddr;
    logic        rclr;
    logic [31:0] raddr;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        rv;
    logic [31:0] ra;
    logic        dv;
    logic [31:0] da;
    logic [31:0] di;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ent_t;

  localparam int QDEPTH = 8;

  // reference model: pc, queued words, and the outstanding request (0 none, 1 live, 2 stale)
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_out;

  int total = 0;
  int bad   = 0;

  function automatic in_t mk(input int rdy, input int ready, input int resp, input logic [31:0] data,
                             input int acc, input int dclr, input logic [31:0] daddr,
                             input int rclr, input logic [31:0] raddr);
    in_t r;
    r.rdy   = (rdy != 0);
    r.ready = (ready != 0);
    r.resp  = (resp != 0);
    r.data  = data;
    r.acc   = (acc != 0);
    r.dclr  = (dclr != 0);
    r.daddr = daddr;
    r.rclr  = (rclr != 0);
    r.raddr = raddr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    rdy_in         = v.rdy;
    mem_req_ready  = v.ready;
    mem_resp_valid = v.resp;
    mem_resp_data  = v.data;
    dec_accept     = v.acc;
    dec_clear      = v.dclr;
    dec_set_addr   = v.daddr;
    rob_clear      = v.rclr;
    rob_set_addr   = v.raddr;
  endtask

  task automatic check_model(input in_t v);
    logic erv;
    erv = v.rdy && (m_out == 0) && (mq.size() < QDEPTH);
    chk("req_valid", 32'(mem_req_valid), 32'(erv));
    chk("req_addr", mem_req_addr, m_pc);
    chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_addr", dec_inst_addr, mq[0].addr);
      chk("head_inst", dec_inst, mq[0].inst);
    end
  endtask

  task automatic model_step(input in_t v);
    logic        redir;
    logic        hs;
    logic [31:0] tgt;
    if (!v.rdy) return;
    redir = v.dclr || v.rclr;
    tgt   = v.rclr ? v.raddr : v.daddr;
    hs    = (m_out == 0) && (mq.size() < QDEPTH) && v.ready;
    if (redir) begin
      mq.delete();
      m_pc = tgt;
      if (v.resp) m_out = 0;
      else if (hs || m_out == 1) m_out = 2;
    end else begin
      if (v.acc && mq.size() > 0) void'(mq.pop_front());
      if (v.resp) begin
        if (m_out == 1) begin
          mq.push_back('{addr: m_pc, inst: v.data});
          m_pc = m_pc + 32'd4;
        end
        m_out = 0;
      end else if (hs) begin
        m_out = 1;
      end
    end
  endtask

  task automatic cycle(input in_t v);
    apply(v);
    #2;
    check_model(v);
    @(posedge clk_in);
    model_step(v);
    #1;
  endtask

  task automatic reset_check(input string tag);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
    chk({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, "_dec_addr"}, dec_inst_addr, 32'h0);
    chk({tag, "_dec_inst"}, dec_inst, 32'h0);
    mq.delete();
    m_pc  = 32'h0;
    m_out = 0;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I2  = 32'h0010_0093;

  vec_t tbl[24];
  in_t  r;

  initial begin
    tbl[0]  = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h000, 1'b0, 32'h000, 32'h0};
    tbl[1]  = '{mk(1,0,1,NOP,0,0,0,0,0),             1'b0, 32'h000, 1'b0, 32'h000, 32'h0};
    tbl[2]  = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h004, 1'b1, 32'h000, NOP};
    tbl[3]  = '{mk(1,0,1,NOP,0,0,0,0,0),             1'b0, 32'h004, 1'b1, 32'h000, NOP};
    tbl[4]  = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h008, 1'b1, 32'h000, NOP};
    tbl[5]  = '{mk(1,0,1,NOP,0,0,0,0,0),             1'b0, 32'h008, 1'b1, 32'h000, NOP};
    tbl[6]  = '{mk(1,0,0,0,1,0,0,0,0),               1'b1, 32'h00c, 1'b1, 32'h000, NOP};
    tbl[7]  = '{mk(1,0,0,0,1,0,0,0,0),               1'b1, 32'h00c, 1'b1, 32'h004, NOP};
    tbl[8]  = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h00c, 1'b1, 32'h008, NOP};
    tbl[9]  = '{mk(1,0,0,0,0,1,32'h100,0,0),         1'b0, 32'h00c, 1'b1, 32'h008, NOP};
    tbl[10] = '{mk(1,0,1,32'hdeadbeef,0,0,0,0,0),    1'b0, 32'h100, 1'b0, 32'h000, 32'h0};
    tbl[11] = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h100, 1'b0, 32'h000, 32'h0};
    tbl[12] = '{mk(1,0,1,I2,0,0,0,0,0),              1'b0, 32'h100, 1'b0, 32'h000, 32'h0};
    tbl[13] = '{mk(1,0,0,0,0,0,0,0,0),               1'b1, 32'h104, 1'b1, 32'h100, I2};
    tbl[14] = '{mk(1,0,0,0,0,1,32'h100,1,32'h200),   1'b1, 32'h104, 1'b1, 32'h100, I2};
    tbl[15] = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h200, 1'b0, 32'h000, 32'h0};
    tbl[16] = '{mk(1,0,1,32'h11111111,0,0,0,1,32'h300), 1'b0, 32'h200, 1'b0, 32'h000, 32'h0};
    tbl[17] = '{mk(1,1,0,0,0,1,32'h400,0,0),         1'b1, 32'h300, 1'b0, 32'h000, 32'h0};
    tbl[18] = '{mk(1,0,0,0,0,0,0,0,0),               1'b0, 32'h400, 1'b0, 32'h000, 32'h0};
    tbl[19] = '{mk(1,0,1,32'h22222222,0,0,0,0,0),    1'b0, 32'h400, 1'b0, 32'h000, 32'h0};
    tbl[20] = '{mk(1,0,0,0,1,0,0,0,0),               1'b1, 32'h400, 1'b0, 32'h000, 32'h0};
    tbl[21] = '{mk(1,1,0,0,0,0,0,0,0),               1'b1, 32'h400, 1'b0, 32'h000, 32'h0};
    tbl[22] = '{mk(1,0,1,32'h33,1,0,0,0,0),          1'b0, 32'h400, 1'b0, 32'h000, 32'h0};
    tbl[23] = '{mk(1,0,0,0,0,0,0,0,0),               1'b1, 32'h404, 1'b1, 32'h400, 32'h33};

    rst_in = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_in);
    reset_check("rst");
    rst_in = 1'b1;

    // directed table: streaming, pops, decoder/ROB redirects in each state
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].in);
      #2;
      check_model(tbl[i].in);
      chk($sformatf("tbl%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_addr", i), mem_req_addr, tbl[i].ra);
      chk($sformatf("tbl%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].dv));
      if (tbl[i].dv) begin
        chk($sformatf("tbl%0d_dec_addr", i), dec_inst_addr, tbl[i].da);
        chk($sformatf("tbl%0d_dec_inst", i), dec_inst, tbl[i].di);
      end
      @(posedge clk_in);
      model_step(tbl[i].in);
      #1;
    end

    // fill the queue to 8 with no decoder accepts, then free one slot
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0));
    for (int i = 0; i < 16; i++)
      cycle(mk(1, (i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0, 32'h1000 + i, 0, 0, 0, 0, 0));
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #1;
    chk("full_req_valid", 32'(mem_req_valid), 32'd0);
    chk("full_dec_valid", 32'(dec_valid), 32'd1);
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
    chk("after_pop_req_valid", 32'(mem_req_valid), 32'd1);
    chk("after_pop_req_addr", mem_req_addr, 32'h20);
    chk("after_pop_head", dec_inst_addr, 32'h4);

    // stall with a request outstanding; accept/clear while stalled must be ignored
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      cycle(mk(0, 1, 0, 0, 1, 1, 32'h500, 0, 0));
      chk($sformatf("stall%0d_req_valid", i), 32'(mem_req_valid), 32'd0);
      chk($sformatf("stall%0d_head", i), dec_inst_addr, 32'h4);
    end
    cycle(mk(1, 0, 1, 32'habc, 0, 0, 0, 0, 0));
    chk("resume_req_addr", mem_req_addr, 32'h24);
    chk("resume_head", dec_inst_addr, 32'h4);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r.rdy   = ($urandom_range(0, 9) != 0);
      r.ready = ($urandom_range(0, 1) == 1);
      r.resp  = r.rdy && (m_out != 0) && ($urandom_range(0, 1) == 1);
      r.data  = $urandom;
      r.acc   = ($urandom_range(0, 9) < 4);
      r.dclr  = ($urandom_range(0, 24) == 0);
      r.daddr = $urandom & 32'hffff_fffc;
      r.rclr  = ($urandom_range(0, 32) == 0);
      r.raddr = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
      cycle(r);
    end

    reset_check("rst2");
    rst_in = 1'b1;
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Issues sequential 32-bit instruction reads to the memory controller and buffers returned words with their PCs in a circular instruction queue.
- Presents the queue head to the decoder.
- Accepts PC redirects from the decoder (jal/jalr/branch) and from the reorder buffer (flush on mispredict/exception), discarding stale in-flight data.

Parameters:
QUEUE_DEPTH_BIT, 3, log2 of queue entries (8 entries)
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low (0 = reset)
rdy_in  input  1  pause when low
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  32  fetch address (word aligned)
mem_req_ready  input  1  memory controller accepts request this cycle
mem_resp_valid  input  1  instruction word returned
mem_resp_data  input  32  returned instruction
dec_valid  output  1  queue head valid
dec_inst_addr  output  32  PC of head
dec_inst  output  32  instruction of head
dec_accept  input  1  decoder consumes head this cycle
dec_clear  input  1  decoder redirect
dec_set_addr  input  32  decoder redirect target
rob_clear  input  1  ROB flush
rob_set_addr  input  32  ROB flush target

Behaviour:
- Reset (rst_in==0 at posedge):
  - pc<=RESET_PC; queue empty; state IDLE.
  - mem_req_valid=0, mem_req_addr=RESET_PC, dec_valid=0, dec_inst_addr=0, dec_inst=0.
- rdy_in==0:
  - All state frozen; mem_req_valid forced 0.
  - The memory controller must not assert mem_resp_valid while rdy_in is low.
- FSM states: IDLE, WAIT_RESP, DROP.
- IDLE:
  - mem_req_valid = !full_incl_inflight, where full_incl_inflight means count == 2^QUEUE_DEPTH_BIT.
  - mem_req_addr = pc.
  - mem_req_valid is driven from registers only; it must not depend combinationally on the redirect inputs.
  - Handshake (valid && ready): latch req_pc<=pc, go WAIT_RESP.
- WAIT_RESP: on mem_resp_valid, push {req_pc, data}, pc<=pc+4 (mod 2^32), go IDLE.
  - The queue always has room, because a request is only issued when not full.
- DROP: on mem_resp_valid, discard the data and go IDLE.
- Redirect (rob_clear || dec_clear):
  - rob_clear has priority; target is rob_set_addr, else dec_set_addr.
  - Same cycle: queue flushed (count<=0), pc<=target.
  - Any push or pop in that cycle is cancelled.
- Next state after a redirect:
  - In WAIT_RESP with no resp this cycle: DROP.
  - In WAIT_RESP with resp this cycle: response discarded, IDLE.
  - In IDLE with handshake this cycle: DROP; the accepted request is stale.
  - In DROP with resp this cycle: IDLE.
  - Otherwise: state unchanged.
- At most one outstanding memory request at any time.
- Decoder side:
  - dec_valid = count!=0; head fields come from a registered queue slot.
  - dec_accept while dec_valid pops the head.
  - dec_accept while !dec_valid is ignored.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
- Latency: response-to-dec_valid is 1 cycle; redirect-to-new mem_req_valid is 1 cycle.
- Pointers are QUEUE_DEPTH_BIT wide and wrap naturally; count is QUEUE_DEPTH_BIT+1 bits.

Optional Feature:
- Macro IF_PERF_EN.
- When defined, adds outputs perf_fetched (32, increments per pushed instruction) and perf_flushes (32, increments per redirect cycle). Both reset to 0 and wrap.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- const.v gets: IF_QUEUE_DEPTH_BIT default, IF state encodings (IF_IDLE/IF_WAIT/IF_DROP), RESET_PC default.
- One sub-module, inst_queue: circular FIFO with push, pop, flush, head outputs and count.
- The FSM, pc, and redirect arbitration stay in inst_fetcher.

Test Plan:
- Reset then mem_req_ready=1, responses 1 cycle later with 0x00000013 → dec_inst_addr 0,4,8 in order, dec_valid 1 cycle after each response.
- dec_accept held 0 → after 8 responses mem_req_valid=0 and count=8. One accept → mem_req_valid=1 next cycle, next request at addr 0x20.
- dec_clear=1, dec_set_addr=0x100 while in WAIT_RESP → queue empties. Response (data 0xdeadbeef) is dropped, next mem_req_addr=0x100, first dec_inst_addr=0x100.
- rob_clear (0x200) and dec_clear (0x100) in the same cycle → next fetch at 0x200, queue empty.
- Response arriving in the same cycle as rob_clear → data not enqueued, state IDLE, request to the target on the next cycle.
- rdy_in=0 for 5 cycles mid-stream → no state change, mem_req_valid=0. Stream resumes unchanged after rdy_in returns high.
